// File: rtl/ps2_seq_pkg.sv
// Shared types and PS/2 set-2 byte constants for the scancode sequencer.
// Used by ps2_scan_seq and ps2_prefix_timer.
package ps2_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Counts idle cycles while a prefix waits for its data byte; expire pulses
// on the PREFIX_TO-th running cycle. PREFIX_TO = 0 never expires.
module ps2_prefix_timer #(
    parameter int PREFIX_TO = 1000000,
    parameter int TO_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);
    import ps2_seq_pkg::*;

    localparam logic [TO_W-1:0] LAST = (PREFIX_TO > 0) ? TO_W'(PREFIX_TO - 1) : '0;

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

    assign expire = (PREFIX_TO != 0) && run && (cnt == LAST);

endmodule

// File: rtl/ps2_scan_seq.sv
// Drains the ps2_keyboard FIFO, folds E0/F0 prefixes into single key events
// and tracks held key / press count / sticky errors. Optional: PS2_TYPEMATIC_FILTER_EN.
module ps2_scan_seq #(
    parameter int CNT_W     = 8,
    parameter int PREFIX_TO = 1000000,
    parameter int TO_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_ready,
    input  logic             fifo_overflow,
    output logic             fifo_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow,
    output logic             err_proto,
    input  logic             err_clr
);
    import ps2_seq_pkg::*;

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_f;
    logic       brk_f;
    logic       tmr_load;
    logic       tmr_run;
    logic       tmr_expire;
    logic       is_repeat;

    // A byte arriving in the same cycle the timer would expire takes priority.
    assign tmr_load = (state == IDLE) && fifo_ready;
    assign tmr_run  = (state == IDLE) && !fifo_ready && (ext_f || brk_f);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign is_repeat = held && !brk_f && (byte_r == held_code) && (ext_f == held_ext);
`else
    assign is_repeat = 1'b0;
`endif

    ps2_prefix_timer #(
        .PREFIX_TO (PREFIX_TO),
        .TO_W      (TO_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .run    (tmr_run),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            byte_r          <= 8'h00;
            ext_f           <= 1'b0;
            brk_f           <= 1'b0;
            fifo_nextdata_n <= 1'b1;
            evt_valid       <= 1'b0;
            evt_code        <= 8'h00;
            evt_ext         <= 1'b0;
            evt_break       <= 1'b0;
            held            <= 1'b0;
            held_code       <= 8'h00;
            held_ext        <= 1'b0;
            press_count     <= '0;
            err_overflow    <= 1'b0;
            err_proto       <= 1'b0;
        end else begin
            if (fifo_overflow)  err_overflow <= 1'b1;
            else if (err_clr)   err_overflow <= 1'b0;

            // Any err_proto set below is a later assignment and wins over the clear.
            if (err_clr) err_proto <= 1'b0;

            case (state)
                IDLE: begin
                    if (fifo_ready) begin
                        byte_r          <= fifo_data;
                        fifo_nextdata_n <= 1'b0;
                        state           <= POP;
                    end else if (tmr_expire) begin
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                        err_proto <= 1'b1;
                    end
                end

                POP: begin
                    fifo_nextdata_n <= 1'b1;
                    state           <= GAP;
                end

                GAP: begin
                    fifo_nextdata_n <= 1'b1;
                    state           <= IDLE;
                    if (byte_r == PS2_EXT) begin
                        ext_f <= 1'b1;
                    end else if (byte_r == PS2_BRK) begin
                        brk_f <= 1'b1;
                    end else if (is_err_byte(byte_r)) begin
                        err_proto <= 1'b1;
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                    end else if (is_repeat) begin
                        ext_f <= 1'b0;
                        brk_f <= 1'b0;
                    end else begin
                        evt_code  <= byte_r;
                        evt_ext   <= ext_f;
                        evt_break <= brk_f;
                        evt_valid <= 1'b1;
                        ext_f     <= 1'b0;
                        brk_f     <= 1'b0;
                        state     <= EMIT;
                    end
                end

                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                        if (!evt_break) begin
                            press_count <= press_count + 1'b1;
                            held        <= 1'b1;
                            held_code   <= evt_code;
                            held_ext    <= evt_ext;
                        end else if (held && (evt_code == held_code) && (evt_ext == held_ext)) begin
                            held <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scan_seq.sv
// Scoreboard bench for ps2_scan_seq: FIFO model, rule-level reference model,
// decoupled event monitor. Honours PS2_TYPEMATIC_FILTER_EN if defined.
module tb_ps2_scan_seq;
  localparam int CNT_W     = 8;
  localparam int PREFIX_TO = 16;
  localparam int TO_W      = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       fifo_data;
  logic             fifo_ready;
  logic             fifo_overflow = 1'b0;
  logic             fifo_nextdata_n;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             held;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_count;
  logic             err_overflow;
  logic             err_proto;
  logic             err_clr = 1'b0;

  ps2_scan_seq #(.CNT_W(CNT_W), .PREFIX_TO(PREFIX_TO), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .fifo_overflow(fifo_overflow), .fifo_nextdata_n(fifo_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .held(held), .held_code(held_code),
    .held_ext(held_ext), .press_count(press_count), .err_overflow(err_overflow),
    .err_proto(err_proto), .err_clr(err_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // FIFO model
  logic [7:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  logic prev_pop = 1'b0;
  assign fifo_ready = (wr_ptr != rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[11:0]];

  always @(negedge clk) begin
    if (!fifo_nextdata_n) begin
      if (prev_pop) begin
        n_checks++;
        $display("FAIL pop_width: strobe low for 2+ cycles");
      end
      if (rd_ptr == wr_ptr) begin
        n_checks++;
        $display("FAIL pop_empty: pop with rd_ptr %0d wr_ptr %0d", rd_ptr, wr_ptr);
      end else begin
        rd_ptr++;
      end
      pops++;
    end
    prev_pop = !fifo_nextdata_n;
  end

  // consumer ready driver
  logic ready_rand  = 1'b0;
  logic ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    evt_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // reference model: {code, ext, brk, held, hcode, hext, cnt}
  logic [27:0] exp_q[$];
  logic       m_ext = 0, m_brk = 0, m_held = 0, m_hext = 0, m_err = 0;
  logic [7:0] m_hcode = 0;
  logic [7:0] m_cnt = 0;

  task automatic model_byte(input logic [7:0] b);
    logic ev_ext, ev_brk, rep;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      ev_ext = m_ext; ev_brk = m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
      rep = m_held && !ev_brk && (b == m_hcode) && (ev_ext == m_hext);
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (rep) return;
`endif
      if (!ev_brk) begin
        m_cnt = m_cnt + 8'd1; m_held = 1'b1; m_hcode = b; m_hext = ev_ext;
      end else if (m_held && b == m_hcode && ev_ext == m_hext) begin
        m_held = 1'b0;
      end
      exp_q.push_back({b, ev_ext, ev_brk, m_held, m_hcode, m_hext, m_cnt});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_err = 0; m_hcode = 0; m_cnt = 0;
  endtask

  // monitor / scoreboard
  int ev_count = 0;
  logic        post_pending = 1'b0;
  logic [17:0] post_exp;
  always @(negedge clk) begin
    logic [27:0] e;
    if (post_pending) begin
      chk("post_held", held, post_exp[17]);
      if (post_exp[17]) chk("post_held_code", {held_code, held_ext}, post_exp[16:8]);
      chk("post_press_count", press_count, post_exp[7:0]);
      post_pending = 1'b0;
    end
    if (!rst && evt_valid && evt_ready) begin
      ev_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: code %0h ext %0b brk %0b", evt_code, evt_ext, evt_break);
      end else begin
        e = exp_q.pop_front();
        chk("event", {evt_code, evt_ext, evt_break}, e[27:18]);
        post_exp = e[17:0];
        post_pending = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    fifo_mem[wr_ptr[11:0]] = b;
    wr_ptr++;
    model_byte(b);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (rd_ptr == wr_ptr && exp_q.size() == 0 && !post_pending) break;
    end
    if (i == 3000) begin
      n_checks++;
      $display("FAIL drain_timeout: rd %0d wr %0d pending %0d", rd_ptr, wr_ptr, exp_q.size());
      exp_q.delete();
    end
    repeat (PREFIX_TO + 10) @(negedge clk);
    if (m_ext || m_brk) begin
      m_ext = 0; m_brk = 0; m_err = 1;
    end
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_press_count"}, press_count, m_cnt);
    chk({tag, "_held"}, held, m_held);
    if (m_held) chk({tag, "_held_code"}, {held_code, held_ext}, {m_hcode, m_hext});
    chk({tag, "_err_proto"}, err_proto, m_err);
    chk({tag, "_evt_valid"}, evt_valid, 1'b0);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_nextdata_n"}, fifo_nextdata_n, 1'b1);
    chk({tag, "_evt"}, {evt_valid, evt_code, evt_ext, evt_break}, 11'd0);
    chk({tag, "_held"}, {held, held_code, held_ext}, 10'd0);
    chk({tag, "_count"}, press_count, 8'd0);
    chk({tag, "_errs"}, {err_overflow, err_proto}, 2'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [0:11];
  initial begin
    int p0, e0, r0, c0;
    logic [9:0] snap;
    pool[0] = 8'h1C; pool[1] = 8'h1C; pool[2] = 8'h75; pool[3] = 8'h23;
    pool[4] = 8'hE0; pool[5] = 8'hF0; pool[6] = 8'hE0; pool[7] = 8'hF0;
    pool[8] = 8'h00; pool[9] = 8'hFF; pool[10] = 8'h5A; pool[11] = 8'h29;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // make, break of the same key
    p0 = pops; e0 = ev_count;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("t1_pops", pops - p0, 3);
    chk("t1_events", ev_count - e0, 2);
    checkpoint("t1");

    // extended make / break, prefixes in either order
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'hE0); send(8'h75);
    drain();
    checkpoint("t2");

    // back-pressure: event held while more bytes wait
    ready_force = 1'b0;
    send(8'h1C); send(8'h23); send(8'h24);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (evt_valid) break;
    end
    chk("t3_valid", evt_valid, 1'b1);
    snap = {evt_code, evt_ext, evt_break};
    r0 = rd_ptr; p0 = pops;
    repeat (10) begin
      @(negedge clk);
      chk("t3_stable", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, snap});
    end
    chk("t3_rd_ptr", rd_ptr, r0);
    chk("t3_no_pop", pops, p0);
    ready_force = 1'b1;
    drain();
    checkpoint("t3");

    // typematic repeats
    e0 = ev_count; c0 = int'(press_count);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t4_events", ev_count - e0, 2);
    chk("t4_presses", (int'(press_count) - c0) & 255, 1);
`else
    chk("t4_events", ev_count - e0, 4);
    chk("t4_presses", (int'(press_count) - c0) & 255, 3);
`endif
    checkpoint("t4");

    // prefix timeout
    pulse_err_clr();
    chk("t5_cleared", err_proto, 1'b0);
    send(8'hF0);
    drain();
    checkpoint("t5a");
    send(8'h1C);
    drain();
    checkpoint("t5b");
    pulse_err_clr();
    chk("t5_clr", err_proto, 1'b0);

    // randomized batches
    ready_rand = 1'b1;
    for (int b = 0; b < 24; b++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) send(pool[$urandom_range(0, 11)]);
      drain();
      checkpoint("rand");
      if ($urandom_range(0, 3) == 0) pulse_err_clr();
    end
    ready_rand = 1'b0;

    // reset while an event is pending
    ready_force = 1'b0;
    send(8'h3A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (evt_valid) break;
    end
    chk("t6_valid", evt_valid, 1'b1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_values("t6");
    rst = 1'b0;
    ready_force = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", evt_valid, 1'b0);
    send(8'h1C);
    drain();
    checkpoint("t6");

    // overflow set beats simultaneous clear
    fifo_overflow = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    fifo_overflow = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("t7_ovf_set", err_overflow, 1'b1);
    pulse_err_clr();
    chk("t7_ovf_clr", err_overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_seq.md
Name: ps2_scan_seq

Overview:
Sequencer that drains the ps2_keyboard receive FIFO through its ready/nextdata_n handshake. It parses PS/2 set-2 scancode sequences (E0 extended prefix, F0 break prefix) into single key events. Events go to the downstream consumer through a valid/ready handshake. The block also tracks the currently held key, counts presses and flags errors. It sits between ps2_keyboard and display/application logic, replacing ad-hoc shift-buffer decoding.

Parameters:
CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.
PREFIX_TO, 1000000, clk cycles a pending prefix may wait for its data byte before being discarded; 0 disables the timeout.
TO_W, 20, width of the prefix timeout counter; must satisfy PREFIX_TO < 2^TO_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fifo_data  in  8  byte at head of ps2_keyboard FIFO
fifo_ready  in  1  FIFO non-empty
fifo_overflow  in  1  FIFO overflow indication
fifo_nextdata_n  out  1  active-low pop strobe to FIFO
evt_valid  out  1  key event available
evt_ready  in  1  consumer accepts event
evt_code  out  8  scancode of event
evt_ext  out  1  event carried E0 prefix
evt_break  out  1  1 = release, 0 = press
held  out  1  a key is currently held
held_code  out  8  code of held key
held_ext  out  1  ext flag of held key
press_count  out  CNT_W  accepted press events
err_overflow  out  1  sticky FIFO overflow seen
err_proto  out  1  sticky: 0x00/0xFF byte or prefix timeout
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (clk edge with rst=1): state IDLE; fifo_nextdata_n=1; evt_valid=0; evt_code=0, evt_ext=0, evt_break=0; held=0, held_code=0, held_ext=0; press_count=0; err_overflow=0, err_proto=0; prefix flags and timeout counter are cleared. Reset during POP/GAP/EMIT abandons the in-flight byte or event with no pop strobe issued afterwards.
- All outputs are registered.
- FSM states: IDLE, POP, GAP, EMIT.
- IDLE: if fifo_ready=1, latch fifo_data into byte_r and go to POP.
- POP: fifo_nextdata_n=0 for exactly this one cycle, then go to GAP.
- GAP: fifo_nextdata_n=1; decode byte_r this cycle, so fifo_ready is not sampled until the FIFO has updated.
  - byte_r=E0: set ext_f, go to IDLE.
  - byte_r=F0: set brk_f, go to IDLE.
  - byte_r=00 or FF: set err_proto, clear both flags, go to IDLE.
  - Otherwise: load evt_code=byte_r, evt_ext=ext_f, evt_break=brk_f, clear both flags, go to EMIT (subject to the filter below).
- Prefix flags are OR-sticky, so E0 F0 xx and F0 E0 xx both give ext=1, break=1.
- EMIT: evt_valid=1, with evt_* held stable until evt_ready=1. On the accepting edge, evt_valid goes 0 and the state returns to IDLE. No FIFO pop occurs while in EMIT.
- Minimum byte-to-byte spacing is 3 cycles. Minimum byte-to-event latency is 3 cycles (evt_valid high in the 4th cycle after fifo_ready is sampled).
- On an accepted press: press_count += 1 (wraps); held=1, held_code=evt_code, held_ext=evt_ext.
- On an accepted release: held=0 only if code and ext match held_code/held_ext; otherwise held is unchanged.
- Prefix timeout: the counter runs while ext_f or brk_f is set and the state is IDLE. On reaching PREFIX_TO it clears the flags and sets err_proto. The counter restarts whenever a byte is latched.
- err_overflow is set on any cycle with fifo_overflow=1. If err_clr and a set condition occur in the same cycle, set wins.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN.
- Defined: a press whose code and ext equal held_code/held_ext while held=1 is discarded in GAP. There is no EMIT and no count, and the state goes to IDLE.
- Undefined: every press is emitted and counted, including typematic repeats.

Decomposition:
- Package ps2_seq_pkg holds:
  - state enum (IDLE, POP, GAP, EMIT);
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF.
- Sub-module ps2_prefix_timer (load/run/expire counter, parameters PREFIX_TO and TO_W) is natural; everything else stays in ps2_scan_seq.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; press_count=1; held 1 then 0; exactly 3 pop strobes, each 1 cycle wide.
- Bytes E0 75, E0 F0 75 -> events {75,ext1,brk0}, {75,ext1,brk1}; held_ext=1 while held; press_count=1.
- Event pending with evt_ready=0 for 10 cycles while fifo_ready=1 -> evt_* stable, no pop strobe, FIFO head unchanged until acceptance.
- 1C,1C,1C then F0 1C -> with PS2_TYPEMATIC_FILTER_EN: 2 events, press_count=1; without: 4 events, press_count=3.
- Byte F0 then idle PREFIX_TO cycles (bench value 16), then 1C -> err_proto=1; event {1C,brk0}; err_clr with no new error clears it.
- rst asserted while in EMIT -> next cycle evt_valid=0, all outputs at reset values; fifo_overflow pulse together with err_clr -> err_overflow=1.
